rom_access_sequencer: RTL and testbench
=======================================

ROM_ACCESS_SEQUENCER -- requirements
Module: rom_access_sequencer

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1024, meaning CLK cycles between dot-matrix scan steps (legal 4..65535).
REQ-002 SHALL have port CLK  in  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port RESET  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports MODE in 2 (0 input, 1 run, 2 debug, 3 treated as run); WR_REQ in 1 (one-cycle write pulse); wr_data in 16 (switch word).
REQ-005 SHALL have ports PAGE_UP in 1 and PAGE_DOWN in 1, both one-cycle pulses.
REQ-006 SHALL have ROM-side ports rom_addr out 11, rom_wdata out 16, ROM_WE out 1, rom_rdata in 16 (synchronous read, valid 1 cycle after address).
REQ-007 SHALL have ports WR_ACK out 1, WR_ERR out 1, page out 8 (7-segment page number), BUSY out 1.
REQ-008 SHALL have matrix-side ports dmd_column_id out 5, dmd_data out 16, DMD_LOAD out 1.

Function
REQ-009 SHALL implement FSM states IDLE, WRITE, VERIFY, SCAN_ADDR, SCAN_LOAD; BUSY=1 in every state except IDLE.
REQ-010 SHALL hold 11-bit write pointer wr_ptr, 6-bit view_page, 5-bit scan column col, 16-bit divider count.
REQ-011 SHALL raise scan tick when divider reaches SCAN_DIV-1, then reload divider to 0; divider runs in all modes.
REQ-012 SHALL latch WR_REQ (only when MODE=0) and scan tick into pending flags; each pending flag cleared when serviced.
REQ-013 SHALL, in IDLE, service pending write before pending tick (write priority); at most one transaction starts per IDLE cycle.
REQ-014 WRITE (1 cycle): rom_addr=wr_ptr, rom_wdata=wr_data captured at request, ROM_WE=1, WR_ACK=1; wr_ptr increments, 2047 wraps to 0.
REQ-015 SCAN_ADDR (1 cycle): rom_addr={scan_page,col}; SCAN_LOAD (1 cycle): dmd_data=rom_rdata, dmd_column_id=col, DMD_LOAD=1; col increments mod 32; return to IDLE.
REQ-016 scan_page SHALL be wr_ptr[10:5] in MODE 0 and view_page otherwise; page output = {2'b00, scan_page}.
REQ-017 SHALL, when scan_page changes, reset col to 0 for the next scan step.
REQ-018 PAGE_UP/PAGE_DOWN SHALL act only in MODE 2, in any state; up wraps 63 to 0, down wraps 0 to 63; simultaneous pulses cause no change.
REQ-019 SHALL, on MODE change mid-transaction, complete the current transaction; pending write dropped if MODE no longer 0.
REQ-020 ROM_WE, WR_ACK, DMD_LOAD SHALL be single-cycle pulses; rom_addr/rom_wdata hold last value outside transactions.

Reset
REQ-021 RESET SHALL asynchronously force state IDLE, wr_ptr=0, view_page=0, col=0, divider=0, pending flags=0.
REQ-022 RESET SHALL force outputs: rom_addr=0, rom_wdata=0, ROM_WE=0, WR_ACK=0, WR_ERR=0, BUSY=0, page=0, dmd_column_id=0, dmd_data=0, DMD_LOAD=0.
REQ-023 RESET asserted mid-transaction SHALL abort it with no ROM_WE or DMD_LOAD pulse after assertion.

Configuration
REQ-024 With macro ROM_SEQ_READBACK_EN defined, WRITE SHALL go to VERIFY: rom_addr=written address for 1 cycle, compare rom_rdata next cycle to written word, mismatch sets sticky WR_ERR (cleared only by RESET); WR_ACK moves to compare cycle.
REQ-025 Without ROM_SEQ_READBACK_EN, VERIFY SHALL be unreachable and WR_ERR tied 0.

Verification
REQ-026 Reset then MODE=0, WR_REQ with wr_data=16'hA5A5 -> next cycle ROM_WE=1, rom_addr=0, rom_wdata=16'hA5A5, WR_ACK=1; wr_ptr=1.
REQ-027 MODE=0, 2048 writes -> rom_addr wraps 2047 to 0; page output 0,1..63,0.
REQ-028 SCAN_DIV=4, MODE=2, view_page=3 -> DMD_LOAD pulses every 4 cycles, rom_addr 96..127, dmd_column_id 0..31 then repeat.
REQ-029 MODE=2: PAGE_DOWN at page 0 -> page 63; PAGE_UP+PAGE_DOWN same cycle -> unchanged; MODE=1 pulses ignored.
REQ-030 MODE=0, WR_REQ and scan tick same cycle -> WRITE first, scan step starts in the following IDLE.
REQ-031 ROM_SEQ_READBACK_EN defined, ROM model corrupts bit 0 -> WR_ERR=1 after compare cycle, stays 1 until RESET.

Source files
------------

// File: rtl/rom_access_sequencer.sv
// ROM access sequencer: services switch-word writes into a 2K x 16 ROM and scans one 32-column page to a dot matrix.
// Optional macro ROM_SEQ_READBACK_EN adds a read-back verify after every write, with sticky error flag WR_ERR.
module rom_access_sequencer #(
    parameter int SCAN_DIV = 1024
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [1:0]  MODE,
    input  logic        WR_REQ,
    input  logic [15:0] wr_data,
    input  logic        PAGE_UP,
    input  logic        PAGE_DOWN,
    output logic [10:0] rom_addr,
    output logic [15:0] rom_wdata,
    output logic        ROM_WE,
    input  logic [15:0] rom_rdata,
    output logic        WR_ACK,
    output logic        WR_ERR,
    output logic [7:0]  page,
    output logic        BUSY,
    output logic [4:0]  dmd_column_id,
    output logic [15:0] dmd_data,
    output logic        DMD_LOAD
);

    localparam logic [2:0]  S_IDLE      = 3'd0;
    localparam logic [2:0]  S_WRITE     = 3'd1;
    localparam logic [2:0]  S_VERIFY    = 3'd2;
    localparam logic [2:0]  S_SCAN_ADDR = 3'd3;
    localparam logic [2:0]  S_SCAN_LOAD = 3'd4;
    localparam logic [15:0] DIV_LAST    = 16'(SCAN_DIV - 1);

    logic [2:0]  state_q, state_d;
    logic [10:0] wr_ptr_q, wr_ptr_d;
    logic [5:0]  view_page_q, view_page_d;
    logic [5:0]  last_page_q, last_page_d;
    logic [4:0]  col_q, col_d;
    logic [15:0] div_q, div_d;
    logic        pend_wr_q, pend_wr_d;
    logic        pend_tick_q, pend_tick_d;
    logic [15:0] wdata_hold_q, wdata_hold_d;
    logic [10:0] rom_addr_q, rom_addr_d;
    logic [15:0] rom_wdata_q, rom_wdata_d;
    logic        rom_we_q, rom_we_d;
    logic        wr_ack_q, wr_ack_d;
    logic [7:0]  page_q, page_d;
    logic        busy_q, busy_d;
    logic [4:0]  dmd_col_q, dmd_col_d;
    logic [15:0] dmd_hold_q, dmd_hold_d;
    logic        dmd_load_q, dmd_load_d;
`ifdef ROM_SEQ_READBACK_EN
    logic        vphase_q, vphase_d;
    logic        err_q, err_d;
`endif

    logic        mode_wr_s;
    logic        wr_now_s;
    logic        tick_s;
    logic [5:0]  scan_page_s;
    logic        page_chg_s;
    logic [4:0]  col_use_s;

    assign mode_wr_s   = (MODE == 2'd0);
    assign wr_now_s    = WR_REQ && mode_wr_s;
    assign tick_s      = (div_q == DIV_LAST);
    assign scan_page_s = mode_wr_s ? wr_ptr_q[10:5] : view_page_q;
    assign page_chg_s  = (scan_page_s != last_page_q);
    // A page switch restarts the scan at column 0 for the next scan step.
    assign col_use_s   = page_chg_s ? 5'd0 : col_q;

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        view_page_d  = view_page_q;
        last_page_d  = scan_page_s;
        col_d        = col_use_s;
        div_d        = tick_s ? 16'd0 : div_q + 16'd1;
        pend_wr_d    = mode_wr_s && (pend_wr_q || WR_REQ);
        pend_tick_d  = pend_tick_q || tick_s;
        wdata_hold_d = wr_now_s ? wr_data : wdata_hold_q;
        rom_addr_d   = rom_addr_q;
        rom_wdata_d  = rom_wdata_q;
        rom_we_d     = 1'b0;
        wr_ack_d     = 1'b0;
        dmd_col_d    = dmd_col_q;
        dmd_hold_d   = dmd_hold_q;
        dmd_load_d   = 1'b0;
`ifdef ROM_SEQ_READBACK_EN
        vphase_d     = vphase_q;
        err_d        = err_q;
`endif
        if ((MODE == 2'd2) && PAGE_UP && !PAGE_DOWN) begin
            view_page_d = view_page_q + 6'd1;
        end else if ((MODE == 2'd2) && PAGE_DOWN && !PAGE_UP) begin
            view_page_d = view_page_q - 6'd1;
        end else begin
            view_page_d = view_page_q;
        end

        case (state_q)
            S_IDLE: begin
                if (pend_wr_d) begin
                    state_d     = S_WRITE;
                    rom_addr_d  = wr_ptr_q;
                    rom_wdata_d = wdata_hold_d;
                    rom_we_d    = 1'b1;
`ifndef ROM_SEQ_READBACK_EN
                    wr_ack_d    = 1'b1;
`endif
                    wr_ptr_d    = wr_ptr_q + 11'd1;
                    pend_wr_d   = 1'b0;
                end else if (pend_tick_d) begin
                    state_d     = S_SCAN_ADDR;
                    rom_addr_d  = {scan_page_s, col_use_s};
                    pend_tick_d = 1'b0;
                end else begin
                    state_d     = S_IDLE;
                end
            end
            S_WRITE: begin
`ifdef ROM_SEQ_READBACK_EN
                state_d  = S_VERIFY;
                vphase_d = 1'b0;
`else
                state_d  = S_IDLE;
`endif
            end
            S_VERIFY: begin
`ifdef ROM_SEQ_READBACK_EN
                // Phase 0 re-presents the written address; phase 1 sees its read data.
                if (!vphase_q) begin
                    vphase_d = 1'b1;
                    wr_ack_d = 1'b1;
                end else begin
                    vphase_d = 1'b0;
                    state_d  = S_IDLE;
                    if (rom_rdata != rom_wdata_q) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end
            S_SCAN_ADDR: begin
                state_d    = S_SCAN_LOAD;
                dmd_load_d = 1'b1;
                dmd_col_d  = rom_addr_q[4:0];
            end
            S_SCAN_LOAD: begin
                state_d    = S_IDLE;
                dmd_hold_d = rom_rdata;
                col_d      = page_chg_s ? 5'd0 : col_q + 5'd1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        page_d = {2'b00, (mode_wr_s ? wr_ptr_d[10:5] : view_page_d)};
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= 11'd0;
            view_page_q  <= 6'd0;
            last_page_q  <= 6'd0;
            col_q        <= 5'd0;
            div_q        <= 16'd0;
            pend_wr_q    <= 1'b0;
            pend_tick_q  <= 1'b0;
            wdata_hold_q <= 16'd0;
            rom_addr_q   <= 11'd0;
            rom_wdata_q  <= 16'd0;
            rom_we_q     <= 1'b0;
            wr_ack_q     <= 1'b0;
            page_q       <= 8'd0;
            busy_q       <= 1'b0;
            dmd_col_q    <= 5'd0;
            dmd_hold_q   <= 16'd0;
            dmd_load_q   <= 1'b0;
`ifdef ROM_SEQ_READBACK_EN
            vphase_q     <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            view_page_q  <= view_page_d;
            last_page_q  <= last_page_d;
            col_q        <= col_d;
            div_q        <= div_d;
            pend_wr_q    <= pend_wr_d;
            pend_tick_q  <= pend_tick_d;
            wdata_hold_q <= wdata_hold_d;
            rom_addr_q   <= rom_addr_d;
            rom_wdata_q  <= rom_wdata_d;
            rom_we_q     <= rom_we_d;
            wr_ack_q     <= wr_ack_d;
            page_q       <= page_d;
            busy_q       <= busy_d;
            dmd_col_q    <= dmd_col_d;
            dmd_hold_q   <= dmd_hold_d;
            dmd_load_q   <= dmd_load_d;
`ifdef ROM_SEQ_READBACK_EN
            vphase_q     <= vphase_d;
            err_q        <= err_d;
`endif
        end
    end

    assign rom_addr      = rom_addr_q;
    assign rom_wdata     = rom_wdata_q;
    assign ROM_WE        = rom_we_q;
    assign WR_ACK        = wr_ack_q;
    assign page          = page_q;
    assign BUSY          = busy_q;
    assign dmd_column_id = dmd_col_q;
    assign DMD_LOAD      = dmd_load_q;
    // ROM read data arrives during SCAN_LOAD itself, so it is passed through then and held afterwards.
    assign dmd_data      = (state_q == S_SCAN_LOAD) ? rom_rdata : dmd_hold_q;
`ifdef ROM_SEQ_READBACK_EN
    assign WR_ERR        = err_q;
`else
    assign WR_ERR        = 1'b0;
`endif

endmodule

// File: tb/tb_rom_access_sequencer.sv
// Directed bench for rom_access_sequencer (SCAN_DIV=4) with a synchronous-read ROM model.
module tb_rom_access_sequencer;

`ifdef ROM_SEQ_READBACK_EN
    localparam int WR_EXTRA = 2;
`else
    localparam int WR_EXTRA = 0;
`endif

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  MODE = 2'd1;
    logic        WR_REQ = 1'b0;
    logic [15:0] wr_data = 16'd0;
    logic        PAGE_UP = 1'b0;
    logic        PAGE_DOWN = 1'b0;
    logic [10:0] rom_addr;
    logic [15:0] rom_wdata;
    logic        ROM_WE;
    logic [15:0] rom_rdata = 16'd0;
    logic        WR_ACK;
    logic        WR_ERR;
    logic [7:0]  page;
    logic        BUSY;
    logic [4:0]  dmd_column_id;
    logic [15:0] dmd_data;
    logic        DMD_LOAD;

    logic [15:0] mem [0:2047];
    logic        mem_ready = 1'b0;
    logic        corrupt = 1'b0;
    int          total = 0;
    int          bad = 0;

    rom_access_sequencer #(.SCAN_DIV(4)) dut (
        .CLK(CLK), .RESET(RESET), .MODE(MODE), .WR_REQ(WR_REQ), .wr_data(wr_data),
        .PAGE_UP(PAGE_UP), .PAGE_DOWN(PAGE_DOWN), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
        .ROM_WE(ROM_WE), .rom_rdata(rom_rdata), .WR_ACK(WR_ACK), .WR_ERR(WR_ERR), .page(page),
        .BUSY(BUSY), .dmd_column_id(dmd_column_id), .dmd_data(dmd_data), .DMD_LOAD(DMD_LOAD)
    );

    always #5 CLK = ~CLK;

    // ROM model: content addr^C3C3 until written; bit 0 of written data flipped when corrupt=1.
    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int a = 0; a < 2048; a++) mem[a] <= 16'(a) ^ 16'hC3C3;
            mem_ready <= 1'b1;
            rom_rdata <= 16'd0;
        end else begin
            if (ROM_WE) mem[rom_addr] <= rom_wdata ^ {15'd0, corrupt};
            rom_rdata <= mem[rom_addr];
        end
    end

    // Holds reset two cycles and releases it on a falling edge; caller continues at that edge.
    task automatic do_reset();
        RESET = 1'b1; MODE = 2'd1; WR_REQ = 1'b0; PAGE_UP = 1'b0; PAGE_DOWN = 1'b0; wr_data = 16'd0;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        logic [60:0] all_out;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        all_out = {rom_addr, rom_wdata, ROM_WE, WR_ACK, WR_ERR, page, BUSY, dmd_column_id, dmd_data, DMD_LOAD};
        total++; if (all_out !== 61'd0) begin bad++; $display("FAIL reset_outputs: got %h want 0", all_out); end
        do_reset();
        MODE = 2'd0; WR_REQ = 1'b1; wr_data = 16'h1111;
        @(negedge CLK);
        WR_REQ = 1'b0;
        total++; if (ROM_WE !== 1'b1) begin bad++; $display("FAIL pre_abort_we: got %b want 1", ROM_WE); end
        RESET = 1'b1;
        #1;
        total++; if ({ROM_WE, BUSY, rom_addr} !== 13'd0) begin bad++; $display("FAIL abort_outputs: got %h want 0", {ROM_WE, BUSY, rom_addr}); end
        repeat (2) @(negedge CLK);
        total++; if ({ROM_WE, DMD_LOAD} !== 2'b00) begin bad++; $display("FAIL abort_no_pulse: got %b want 00", {ROM_WE, DMD_LOAD}); end
    endtask

    task automatic test_first_write();
        logic got;
        do_reset();
        MODE = 2'd0; WR_REQ = 1'b1; wr_data = 16'hA5A5;
        @(negedge CLK);
        total++; if (ROM_WE !== 1'b1) begin bad++; $display("FAIL first_we: got %b want 1", ROM_WE); end
        total++; if (rom_addr !== 11'd0) begin bad++; $display("FAIL first_addr: got %0d want 0", rom_addr); end
        total++; if (rom_wdata !== 16'hA5A5) begin bad++; $display("FAIL first_wdata: got %h want a5a5", rom_wdata); end
        total++; if (WR_ACK !== (WR_EXTRA == 0)) begin bad++; $display("FAIL first_ack: got %b want %b", WR_ACK, (WR_EXTRA == 0)); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL first_busy: got %b want 1", BUSY); end
        wr_data = 16'h1234;
        @(negedge CLK);
        WR_REQ = 1'b0; wr_data = 16'hFFFF;
        total++; if ({ROM_WE, WR_ERR} !== 2'b00) begin bad++; $display("FAIL we_single_pulse: got %b want 00", {ROM_WE, WR_ERR}); end
        got = 1'b0;
        for (int w = 0; w < 8; w++) begin
            if (ROM_WE === 1'b1) begin got = 1'b1; break; end
            @(negedge CLK);
        end
        total++; if (got !== 1'b1) begin bad++; $display("FAIL second_write_seen: got %b want 1", got); end
        total++; if (rom_addr !== 11'd1) begin bad++; $display("FAIL second_addr: got %0d want 1", rom_addr); end
        total++; if (rom_wdata !== 16'h1234) begin bad++; $display("FAIL second_wdata: got %h want 1234", rom_wdata); end
    endtask

    task automatic test_write_vs_tick();
        do_reset();
        MODE = 2'd0;
        repeat (3) @(negedge CLK);
        WR_REQ = 1'b1; wr_data = 16'hBEEF;
        @(negedge CLK);
        WR_REQ = 1'b0;
        total++; if ({ROM_WE, DMD_LOAD} !== 2'b10) begin bad++; $display("FAIL tie_write_first: got %b want 10", {ROM_WE, DMD_LOAD}); end
        repeat (WR_EXTRA + 1) @(negedge CLK);
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL tie_idle_between: got %b want 0", BUSY); end
        @(negedge CLK);
        total++; if ({BUSY, ROM_WE, rom_addr} !== {1'b1, 1'b0, 11'd0}) begin bad++; $display("FAIL tie_scan_addr: got %h want %h", {BUSY, ROM_WE, rom_addr}, {1'b1, 1'b0, 11'd0}); end
        @(negedge CLK);
        total++; if ({DMD_LOAD, dmd_column_id, dmd_data} !== {1'b1, 5'd0, 16'hBEEF}) begin bad++; $display("FAIL tie_scan_load: got %h want %h", {DMD_LOAD, dmd_column_id, dmd_data}, {1'b1, 5'd0, 16'hBEEF}); end
    endtask

    task automatic test_scan();
        int k;
        logic [4:0]  ec;
        logic [15:0] ed;
        do_reset();
        MODE = 2'd2; PAGE_UP = 1'b1;
        repeat (3) @(negedge CLK);
        PAGE_UP = 1'b0;
        total++; if (page !== 8'd3) begin bad++; $display("FAIL scan_view_page: got %0d want 3", page); end
        for (int n = 4; n <= 170; n++) begin
            @(negedge CLK);
            if (n >= 5 && ((n - 5) % 4) == 0) begin
                k = (n - 5) / 4;
                ec = 5'(k % 32);
                ed = 16'(96 + (k % 32)) ^ 16'hC3C3;
                total++; if ({DMD_LOAD, dmd_column_id} !== {1'b1, ec}) begin bad++; $display("FAIL scan_load_col n=%0d: got %h want %h", n, {DMD_LOAD, dmd_column_id}, {1'b1, ec}); end
                total++; if (rom_addr !== (11'd96 + 11'(ec))) begin bad++; $display("FAIL scan_addr n=%0d: got %0d want %0d", n, rom_addr, 96 + ec); end
                total++; if (dmd_data !== ed) begin bad++; $display("FAIL scan_data n=%0d: got %h want %h", n, dmd_data, ed); end
            end else begin
                total++; if (DMD_LOAD !== 1'b0) begin bad++; $display("FAIL scan_no_load n=%0d: got %b want 0", n, DMD_LOAD); end
            end
        end
    endtask

    task automatic test_page_buttons();
        do_reset();
        MODE = 2'd2; PAGE_DOWN = 1'b1;
        @(negedge CLK);
        PAGE_DOWN = 1'b0;
        total++; if (page !== 8'd63) begin bad++; $display("FAIL page_down_wrap: got %0d want 63", page); end
        PAGE_UP = 1'b1; PAGE_DOWN = 1'b1;
        @(negedge CLK);
        PAGE_UP = 1'b0; PAGE_DOWN = 1'b0;
        total++; if (page !== 8'd63) begin bad++; $display("FAIL page_both: got %0d want 63", page); end
        MODE = 2'd1; PAGE_UP = 1'b1;
        @(negedge CLK);
        PAGE_UP = 1'b0; PAGE_DOWN = 1'b1;
        total++; if (page !== 8'd63) begin bad++; $display("FAIL page_mode1_up: got %0d want 63", page); end
        @(negedge CLK);
        PAGE_DOWN = 1'b0;
        total++; if (page !== 8'd63) begin bad++; $display("FAIL page_mode1_down: got %0d want 63", page); end
        MODE = 2'd2; PAGE_UP = 1'b1;
        @(negedge CLK);
        PAGE_UP = 1'b0;
        total++; if (page !== 8'd0) begin bad++; $display("FAIL page_up_wrap: got %0d want 0", page); end
    endtask

    task automatic test_mode_change();
        logic seen_we;
        do_reset();
        repeat (4) @(negedge CLK);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL mc_in_scan: got %b want 1", BUSY); end
        MODE = 2'd0; WR_REQ = 1'b1; wr_data = 16'h7777;
        @(negedge CLK);
        WR_REQ = 1'b0; MODE = 2'd1;
        total++; if (DMD_LOAD !== 1'b1) begin bad++; $display("FAIL mc_scan_completes: got %b want 1", DMD_LOAD); end
        seen_we = 1'b0;
        repeat (8) begin
            @(negedge CLK);
            if (ROM_WE !== 1'b0) seen_we = 1'b1;
        end
        total++; if (seen_we !== 1'b0) begin bad++; $display("FAIL mc_write_dropped: got %b want 0", seen_we); end
    endtask

    task automatic test_wrap();
        logic       got;
        logic [7:0] ep;
        do_reset();
        MODE = 2'd0;
        for (int i = 0; i <= 2048; i++) begin
            WR_REQ = 1'b1; wr_data = 16'(i) ^ 16'h5A5A;
            got = 1'b0;
            for (int w = 0; w < 10; w++) begin
                @(negedge CLK);
                if (w == 0) WR_REQ = 1'b0;
                if (ROM_WE === 1'b1) begin got = 1'b1; break; end
            end
            ep = 8'(((i + 1) % 2048) >> 5);
            total++; if (got !== 1'b1) begin bad++; $display("FAIL wrap_seen i=%0d: got %b want 1", i, got); end
            total++; if (rom_addr !== 11'(i)) begin bad++; $display("FAIL wrap_addr i=%0d: got %0d want %0d", i, rom_addr, 11'(i)); end
            total++; if (page !== ep) begin bad++; $display("FAIL wrap_page i=%0d: got %0d want %0d", i, page, ep); end
        end
    endtask

`ifdef ROM_SEQ_READBACK_EN
    task automatic test_readback();
        logic stuck;
        do_reset();
        MODE = 2'd0; corrupt = 1'b0; WR_REQ = 1'b1; wr_data = 16'h0F0F;
        @(negedge CLK);
        WR_REQ = 1'b0;
        total++; if ({ROM_WE, WR_ACK} !== 2'b10) begin bad++; $display("FAIL rb_write_cycle: got %b want 10", {ROM_WE, WR_ACK}); end
        @(negedge CLK);
        total++; if ({ROM_WE, rom_addr} !== 12'd0) begin bad++; $display("FAIL rb_verify_addr: got %h want 0", {ROM_WE, rom_addr}); end
        @(negedge CLK);
        total++; if (WR_ACK !== 1'b1) begin bad++; $display("FAIL rb_ack: got %b want 1", WR_ACK); end
        @(negedge CLK);
        total++; if (WR_ERR !== 1'b0) begin bad++; $display("FAIL rb_no_err: got %b want 0", WR_ERR); end
        corrupt = 1'b1; WR_REQ = 1'b1; wr_data = 16'h3C3C;
        @(negedge CLK);
        WR_REQ = 1'b0;
        total++; if ({ROM_WE, rom_addr} !== {1'b1, 11'd1}) begin bad++; $display("FAIL rb_write2: got %h want %h", {ROM_WE, rom_addr}, {1'b1, 11'd1}); end
        repeat (3) @(negedge CLK);
        total++; if (WR_ERR !== 1'b1) begin bad++; $display("FAIL rb_err_set: got %b want 1", WR_ERR); end
        corrupt = 1'b0;
        stuck = 1'b1;
        repeat (10) begin
            @(negedge CLK);
            if (WR_ERR !== 1'b1) stuck = 1'b0;
        end
        total++; if (stuck !== 1'b1) begin bad++; $display("FAIL rb_err_sticky: got %b want 1", stuck); end
        RESET = 1'b1;
        #1;
        total++; if (WR_ERR !== 1'b0) begin bad++; $display("FAIL rb_err_reset: got %b want 0", WR_ERR); end
    endtask
`endif

    initial begin
        test_reset();
        test_first_write();
        test_write_vs_tick();
        test_scan();
        test_page_buttons();
        test_mode_change();
`ifdef ROM_SEQ_READBACK_EN
        test_readback();
`endif
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
